// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_pkg
//  Brief   : Shared defaults, FSM state encoding and requester ids for the
//            dual-requester register-file arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DW_DEF = 64;
    localparam int AW_DEF = 4;

    // Requester ids, also used as the round-robin "last granted" encoding
    localparam logic RID_A = 1'b0;
    localparam logic RID_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arb2
//  Brief   : Two-way round-robin arbiter. Grant is combinational while en is
//            high; the "last granted" pointer advances on every grant.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,     // asynchronous, active-low
    input  logic       en,
    input  logic [1:0] req,     // [0] = A, [1] = B
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // Grant selection: on contention favour the side not granted last time
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (last_q == RID_B) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
        if (gnt[0]) begin
            last_d = RID_A;
        end else if (gnt[1]) begin
            last_d = RID_B;
        end
    end

    // Pointer register; resets to "last = B" so A wins the first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= RID_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/regfile_arb.sv
`default_nettype none
// ============================================================================
//  Module  : regfile_arb
//  Brief   : Serialises write / two-operand read transactions from two
//            requesters onto a single external register-file port.
//            IDLE -> ISSUE (strobe) -> CAPTURE (reads only) -> IDLE.
//  Rev     : 1.0  initial release
// ============================================================================
module regfile_arb
    import regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,      // asynchronous, active-low
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] wa_a,
    input  logic [AW-1:0] wa_b,
    input  logic [DW-1:0] wd_a,
    input  logic [DW-1:0] wd_b,
    input  logic [AW-1:0] ra1_a,
    input  logic [AW-1:0] ra1_b,
    input  logic [AW-1:0] ra2_a,
    input  logic [AW-1:0] ra2_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid,
    output logic          rid,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic          busy,
    output logic          rf_en,
    output logic          rf_rd,
    output logic          rf_wr,
    output logic [AW-1:0] rf_si1,
    output logic [AW-1:0] rf_so1,
    output logic [AW-1:0] rf_so2,
    output logic [DW-1:0] rf_i1,
    input  logic [DW-1:0] rf_o1,
    input  logic [DW-1:0] rf_o2
);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic          owner_q, owner_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [AW-1:0] ra1_q, ra1_d;
    logic [AW-1:0] ra2_q, ra2_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [DW-1:0] rdata2_q, rdata2_d;
    logic          rid_q, rid_d;

    logic [1:0]    arb_gnt;
    logic          arb_en;
    logic          in_issue;

    // Arbitration only while idle; gated by reset so grants drop immediately
    assign arb_en = (state_q == ST_IDLE) && rst;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({req_b, req_a}),
        .gnt (arb_gnt)
    );

    // Next-state, request latching and read-data capture
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        owner_d  = owner_q;
        wa_d     = wa_q;
        ra1_d    = ra1_q;
        ra2_d    = ra2_q;
        wd_d     = wd_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        rid_d    = rid_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_gnt[0]) begin
                    we_d    = we_a;
                    owner_d = RID_A;
                    wa_d    = wa_a;
                    ra1_d   = ra1_a;
                    ra2_d   = ra2_a;
                    wd_d    = wd_a;
                    state_d = ST_ISSUE;
                end else if (arb_gnt[1]) begin
                    we_d    = we_b;
                    owner_d = RID_B;
                    wa_d    = wa_b;
                    ra1_d   = ra1_b;
                    ra2_d   = ra2_b;
                    wd_d    = wd_b;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    // Register-file data is valid only while rf_rd is high
                    rdata1_d = rf_o1;
                    rdata2_d = rf_o2;
                    rid_d    = owner_q;
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            owner_q  <= RID_A;
            wa_q     <= '0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            wd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            rid_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            owner_q  <= owner_d;
            wa_q     <= wa_d;
            ra1_q    <= ra1_d;
            ra2_q    <= ra2_d;
            wd_q     <= wd_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            rid_q    <= rid_d;
        end
    end

    // Output decode: strobes and addresses are driven only during ISSUE
    assign in_issue = (state_q == ST_ISSUE);
    assign gnt_a    = arb_gnt[0];
    assign gnt_b    = arb_gnt[1];
    assign busy     = (state_q != ST_IDLE);
    assign rvalid   = (state_q == ST_CAPTURE);
    assign rid      = rid_q;
    assign rdata1   = rdata1_q;
    assign rdata2   = rdata2_q;
    assign rf_en    = in_issue;
    assign rf_wr    = in_issue & we_q;
    assign rf_rd    = in_issue & ~we_q;
    assign rf_si1   = rf_wr ? wa_q  : '0;
    assign rf_i1    = rf_wr ? wd_q  : '0;
    assign rf_so1   = rf_rd ? ra1_q : '0;
    assign rf_so2   = rf_rd ? ra2_q : '0;

endmodule : regfile_arb
`default_nettype wire

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Interface
REQ-001 Parameter DW, default 64, SHALL set data width.
REQ-002 Parameter AW, default 4, SHALL set register address width.
REQ-003 Ports SHALL be:
  clk  in  1  sole clock, rising edge.
  rst  in  1  reset, asynchronous, active-low.
  req_a/req_b  in  1  request from requester A/B.
  we_a/we_b  in  1  1 = write, 0 = two-operand read.
  wa_a/wa_b  in  AW  write address.
  wd_a/wd_b  in  DW  write data.
  ra1_a/ra1_b, ra2_a/ra2_b  in  AW  read addresses.
  gnt_a/gnt_b  out  1  one-cycle grant pulse.
  rvalid  out  1  one-cycle read-data-valid pulse.
  rid  out  1  requester of rvalid data (0 = A, 1 = B).
  rdata1/rdata2  out  DW  read operands.
  busy  out  1  FSM not in IDLE.
  rf_en/rf_rd/rf_wr  out  1  register file enable/read/write strobes.
  rf_si1/rf_so1/rf_so2  out  AW  register file write/read addresses.
  rf_i1  out  DW  register file write data.
  rf_o1/rf_o2  in  DW  register file read data, valid in the same cycle rf_rd is high.

Function
REQ-004 FSM SHALL have states IDLE, ISSUE, CAPTURE.
REQ-005 In IDLE with any req high: pick winner, latch its we/addresses/data, pulse its gnt, go to ISSUE; otherwise stay in IDLE.
REQ-006 Arbitration: round-robin; if both request, grant the one not granted last; if one requests, grant it.
REQ-007 Requester SHALL hold req and fields stable until gnt; req high in the cycle after gnt is a new request.
REQ-008 ISSUE: rf_en=1; write -> rf_wr=1, rf_si1/rf_i1 from latch, then IDLE; read -> rf_rd=1, rf_so1/rf_so2 from latch, then CAPTURE.
REQ-009 CAPTURE: register the rf_o1/rf_o2 values present in ISSUE into rdata1/rdata2, pulse rvalid with rid, then IDLE.
REQ-010 Latency: gnt in cycle T; rf strobe in T+1; rvalid in T+2; next gnt no earlier than T+2 (write) or T+3 (read).
REQ-011 rf_en, rf_rd and rf_wr SHALL be 0 outside ISSUE; rf_rd and rf_wr are never both 1.
REQ-012 rdata1/rdata2/rid SHALL hold their last values until the next rvalid.
REQ-013 Requests arriving while busy=1 SHALL be ignored until IDLE; no queueing.
REQ-014 Both requesters continuously requesting SHALL alternate grants; bounded wait is one transaction.
REQ-015 Read of the address written by the immediately preceding transaction SHALL return the new data, because transactions are strictly serial.

Reset
REQ-016 rst low SHALL force IDLE at once: gnt_*, rvalid, rid, busy, rf_* strobes, addresses, rf_i1 and rdata* all 0.
REQ-017 Round-robin pointer SHALL reset to "last = B", so A wins the first contention.
REQ-018 Reset mid-transaction SHALL drop the transaction: no rvalid and no rf_wr after release.

Structure
REQ-019 Package regfile_pkg SHALL hold DW/AW defaults, the state enum and the requester-id constants.
REQ-020 Sub-module rr_arb2 (2-way round-robin arbiter with pointer update on grant) SHALL be instantiated once.

Verification
REQ-021 After reset, A writes 0x0123_4567_89AB_CDEF to r5 -> gnt_a at T, rf_wr=1/rf_si1=5 at T+1, busy low at T+2.
REQ-022 Then A reads r5/r0 -> rvalid at T+2, rid=0, rdata1=0x0123_4567_89AB_CDEF, rdata2=0.
REQ-023 req_a and req_b both high from reset release for 6 grants -> order A,B,A,B,A,B.
REQ-024 req_b alone while FSM is in CAPTURE of A's read -> no gnt_b until IDLE, then gnt_b.
REQ-025 rst low in ISSUE of a read -> rvalid never pulses and all outputs are 0 in the same cycle.
REQ-026 Write r3 by B, then read r3 by A back-to-back -> rdata1 equals B's data.
